dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: byte-addressable data memory with a one-entry store buffer,
// load forwarding from the buffer, and sticky misalignment error tracking.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  input  logic [3:0]  READ_WRITE,
  output logic [31:0] READDATA,
  output logic        MISALIGNED,
  output logic [7:0]  ERR_COUNT
);

  localparam int IW = $clog2(DEPTH_WORDS);

  localparam logic [3:0] OP_LB  = 4'b1000;
  localparam logic [3:0] OP_LH  = 4'b1001;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_LBU = 4'b1100;
  localparam logic [3:0] OP_LHU = 4'b1101;
  localparam logic [3:0] OP_SB  = 4'b0100;
  localparam logic [3:0] OP_SH  = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b0110;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          buf_valid;
  logic [IW-1:0] buf_idx;
  logic [31:0]   buf_data;
  logic [3:0]    buf_mask;

  logic [IW-1:0] idx;
  logic          is_store;
  logic          misaligned_now;
  logic          store_ok;
  logic          same_word;
  logic          commit;
  logic [31:0]   st_data;
  logic [3:0]    st_mask;
  logic [31:0]   src_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          unused_addr;

  assign idx         = ADDRESS[IW+1:2];
  assign unused_addr = ^ADDRESS[31:IW+2];

  always_comb begin
    is_store       = 1'b0;
    misaligned_now = 1'b0;
    st_data        = '0;
    st_mask        = '0;
    case (READ_WRITE)
      OP_LH, OP_LHU: misaligned_now = ADDRESS[0];
      OP_LW:         misaligned_now = (ADDRESS[1:0] != 2'b00);
      OP_SB: begin
        is_store = 1'b1;
        st_data  = {4{WRITEDATA[7:0]}};
        st_mask  = 4'b0001 << ADDRESS[1:0];
      end
      OP_SH: begin
        is_store       = 1'b1;
        misaligned_now = ADDRESS[0];
        st_data        = {2{WRITEDATA[15:0]}};
        st_mask        = ADDRESS[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        is_store       = 1'b1;
        misaligned_now = (ADDRESS[1:0] != 2'b00);
        st_data        = WRITEDATA;
        st_mask        = 4'b1111;
      end
      default: ;
    endcase
  end

  assign store_ok  = is_store && !misaligned_now;
  assign same_word = buf_valid && (buf_idx == idx);
  // A merging store keeps the buffer resident; any other edge drains it.
  assign commit    = !RESET && buf_valid && !(store_ok && same_word);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_valid <= 1'b0;
    end else if (store_ok) begin
      buf_valid <= 1'b1;
      if (same_word) begin
        for (int b = 0; b < 4; b++) begin
          if (st_mask[b]) buf_data[8*b +: 8] <= st_data[8*b +: 8];
        end
        buf_mask <= buf_mask | st_mask;
      end else begin
        buf_idx  <= idx;
        buf_data <= st_data;
        buf_mask <= st_mask;
      end
    end else if (buf_valid) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_mask[b]) mem[buf_idx][8*b +: 8] <= buf_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MISALIGNED <= 1'b0;
      ERR_COUNT  <= '0;
    end else if (misaligned_now) begin
      MISALIGNED <= 1'b1;
      if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  always_comb begin
    src_word = mem[idx];
    if (same_word) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_mask[b]) src_word[8*b +: 8] = buf_data[8*b +: 8];
      end
    end
  end

  assign sel_byte = src_word[8*ADDRESS[1:0] +: 8];
  assign sel_half = ADDRESS[1] ? src_word[31:16] : src_word[15:0];

  always_comb begin
    READDATA = '0;
    if (!misaligned_now) begin
      case (READ_WRITE)
        OP_LB:   READDATA = {{24{sel_byte[7]}}, sel_byte};
        OP_LBU:  READDATA = {24'h0, sel_byte};
        OP_LH:   READDATA = {{16{sel_half[15]}}, sel_half};
        OP_LHU:  READDATA = {16'h0, sel_half};
        OP_LW:   READDATA = src_word;
        default: READDATA = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Directed table-driven bench for dmem_responder.
module tb_dmem_responder;

  localparam logic [3:0] NOP = 4'b0000, LB = 4'b1000, LH = 4'b1001, LW = 4'b1010,
                         LBU = 4'b1100, LHU = 4'b1101, SB = 4'b0100, SH = 4'b0101,
                         SW = 4'b0110;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  rw;
  logic        mis;
  logic [7:0]  cnt;

  dmem_responder #(.DEPTH_WORDS(1024)) dut (
    .CLK(clk), .RESET(rst), .ADDRESS(addr), .WRITEDATA(wdata),
    .READ_WRITE(rw), .READDATA(rdata), .MISALIGNED(mis), .ERR_COUNT(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tab1[$];
  vec_t tab2[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(string n, logic r, logic [3:0] c, logic [31:0] a,
                              logic [31:0] d, logic [31:0] e, logic m, logic [7:0] k);
    vec_t v;
    v.name = n; v.rst = r; v.rw = c; v.addr = a; v.wdata = d;
    v.exp_rd = e; v.exp_mis = m; v.exp_cnt = k;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  // Flag expectations are the state left by earlier edges.
  task automatic apply(vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; rw = v.rw; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    check({v.name, ".rd"}, rdata, v.exp_rd);
    check({v.name, ".mis"}, {31'h0, mis}, {31'h0, v.exp_mis});
    check({v.name, ".cnt"}, {24'h0, cnt}, {24'h0, v.exp_cnt});
  endtask

  initial begin
    rst = 1'b1; rw = NOP; addr = '0; wdata = '0;

    tab1.push_back(mk("reset",      1, NOP, 32'h0,  32'h0,        32'h0,        0, 0));
    tab1.push_back(mk("idle",       0, NOP, 32'h0,  32'h0,        32'h0,        0, 0));
    tab1.push_back(mk("sw10",       0, SW,  32'h10, 32'h11223344, 32'h0,        0, 0));
    tab1.push_back(mk("lw10_fwd",   0, LW,  32'h10, 32'h0,        32'h11223344, 0, 0));
    tab1.push_back(mk("nop",        0, NOP, 32'h10, 32'h0,        32'h0,        0, 0));
    tab1.push_back(mk("lw10_arr",   0, LW,  32'h10, 32'h0,        32'h11223344, 0, 0));
    tab1.push_back(mk("sw20",       0, SW,  32'h20, 32'hAABBCCDD, 32'h0,        0, 0));
    tab1.push_back(mk("sb21_merge", 0, SB,  32'h21, 32'h0000007F, 32'h0,        0, 0));
    tab1.push_back(mk("lw20",       0, LW,  32'h20, 32'h0,        32'hAABB7FDD, 0, 0));
    tab1.push_back(mk("lb23",       0, LB,  32'h23, 32'h0,        32'hFFFFFFAA, 0, 0));
    tab1.push_back(mk("lbu23",      0, LBU, 32'h23, 32'h0,        32'h000000AA, 0, 0));
    tab1.push_back(mk("lhu22",      0, LHU, 32'h22, 32'h0,        32'h0000AABB, 0, 0));
    tab1.push_back(mk("sh32",       0, SH,  32'h32, 32'h00008001, 32'h0,        0, 0));
    tab1.push_back(mk("lh32_fwd",   0, LH,  32'h32, 32'h0,        32'hFFFF8001, 0, 0));
    tab1.push_back(mk("lhu32_arr",  0, LHU, 32'h32, 32'h0,        32'h00008001, 0, 0));
    tab1.push_back(mk("sw60",       0, SW,  32'h60, 32'h01020304, 32'h0,        0, 0));
    tab1.push_back(mk("sb64_evict", 0, SB,  32'h64, 32'h000000EE, 32'h0,        0, 0));
    tab1.push_back(mk("lw60_arr",   0, LW,  32'h60, 32'h0,        32'h01020304, 0, 0));
    tab1.push_back(mk("lbu64_arr",  0, LBU, 32'h64, 32'h0,        32'h000000EE, 0, 0));
    tab1.push_back(mk("sw40",       0, SW,  32'h40, 32'h0BADF00D, 32'h0,        0, 0));
    tab1.push_back(mk("lw41_mis",   0, LW,  32'h41, 32'h0,        32'h0,        0, 0));
    tab1.push_back(mk("sw42_mis",   0, SW,  32'h42, 32'hDEADBEEF, 32'h0,        1, 1));
    tab1.push_back(mk("lw40_kept",  0, LW,  32'h40, 32'h0,        32'h0BADF00D, 1, 2));
    tab1.push_back(mk("lhu33_mis",  0, LHU, 32'h33, 32'h0,        32'h0,        1, 2));
    tab1.push_back(mk("sb43",       0, SB,  32'h43, 32'h00000099, 32'h0,        1, 3));
    tab1.push_back(mk("lw40_fwd",   0, LW,  32'h40, 32'h0,        32'h99ADF00D, 1, 3));

    tab2.push_back(mk("sw50_pre",   0, SW,  32'h50, 32'h12345678, 32'h0,        1, 255));
    tab2.push_back(mk("commit50",   0, NOP, 32'h50, 32'h0,        32'h0,        1, 255));
    tab2.push_back(mk("sw50_5",     0, SW,  32'h50, 32'h00000005, 32'h0,        1, 255));
    tab2.push_back(mk("rst_drop",   1, NOP, 32'h50, 32'h0,        32'h0,        1, 255));
    tab2.push_back(mk("lw50_old",   0, LW,  32'h50, 32'h0,        32'h12345678, 0, 0));
    tab2.push_back(mk("nop2",       0, NOP, 32'h50, 32'h0,        32'h0,        0, 0));
    tab2.push_back(mk("lw50_again", 0, LW,  32'h50, 32'h0,        32'h12345678, 0, 0));
    tab2.push_back(mk("sw1004",     0, SW,  32'h1004, 32'hCAFE0000, 32'h0,      0, 0));
    tab2.push_back(mk("lw4_fwd",    0, LW,  32'h4,  32'h0,        32'hCAFE0000, 0, 0));
    tab2.push_back(mk("nop3",       0, NOP, 32'h4,  32'h0,        32'h0,        0, 0));
    tab2.push_back(mk("lw4_arr",    0, LW,  32'h4,  32'h0,        32'hCAFE0000, 0, 0));
    tab2.push_back(mk("lw_hi_wrap", 0, LW,  32'hFFFF1004, 32'h0,  32'hCAFE0000, 0, 0));
    tab2.push_back(mk("code0111",   0, 4'b0111, 32'h4, 32'h0,     32'h0,        0, 0));
    tab2.push_back(mk("code1011",   0, 4'b1011, 32'h4, 32'h0,     32'h0,        0, 0));
    tab2.push_back(mk("lw4_intact", 0, LW,  32'h4,  32'h0,        32'hCAFE0000, 0, 0));

    foreach (tab1[i]) apply(tab1[i]);

    // 300 misaligned loads on top of the 3 errors already counted.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0; rw = LW; addr = 32'h41; wdata = '0;
      @(negedge clk);
      if (i == 0)   check("sat.rd", rdata, 32'h0);
      if (i == 251) check("sat.cnt254", {24'h0, cnt}, 32'd254);
      if (i == 252) check("sat.cnt255", {24'h0, cnt}, 32'd255);
    end

    foreach (tab2[i]) apply(tab2[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
